// File: rtl/fir_pkg.sv
// fir_pkg: width helpers shared by the decimating and interpolating FIR stages
package fir_pkg;
    function automatic int acc_width(input int dw, input int cw, input int nt);
        return dw + cw + $clog2(nt);
    endfunction
    function automatic int phase_width(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction
endpackage

// File: rtl/fir_sat_narrow.sv
// fir_sat_narrow: arithmetic shift then narrow to DATA_WIDTH, clamping when FIR_DECIM_SAT_EN is defined, wrapping otherwise
module fir_sat_narrow #(
    parameter int ACC_WIDTH  = 16,
    parameter int DATA_WIDTH = 5,
    parameter int SHIFT      = 4
) (
    input  logic signed [ACC_WIDTH-1:0]  acc,
    output logic signed [DATA_WIDTH-1:0] y
);
`ifdef FIR_DECIM_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] MAXV = {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] MINV = {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    logic signed [ACC_WIDTH-1:0] sh;
    always_comb begin
        sh = acc >>> SHIFT;
        y  = (sh > MAXV) ? MAXV[DATA_WIDTH-1:0] : (sh < MINV) ? MINV[DATA_WIDTH-1:0] : sh[DATA_WIDTH-1:0];
    end
`else
    always_comb y = DATA_WIDTH'(acc >>> SHIFT);
`endif
endmodule

// File: rtl/fir_decim_nom.sv
// fir_decim_nom: direct-form decimating FIR, one output per DECIM_FACTOR accepted samples.
// Output narrowing saturates when FIR_DECIM_SAT_EN is defined, wraps otherwise.
module fir_decim_nom
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH      = 5,
    parameter int TAP_COEFF_WIDTH = 5,
    parameter int NUM_TAPS        = 50,
    parameter int DECIM_FACTOR    = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic signed [DATA_WIDTH-1:0]      in,
    input  logic                              in_valid,
    input  logic signed [TAP_COEFF_WIDTH-1:0] tap_coeffs [NUM_TAPS],
    output logic signed [DATA_WIDTH-1:0]      out,
    output logic                              out_valid
);
    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, TAP_COEFF_WIDTH, NUM_TAPS);
    localparam int PW        = phase_width(DECIM_FACTOR);
    localparam logic [PW-1:0] LAST_PH = PW'(DECIM_FACTOR - 1);

    typedef logic signed [DATA_WIDTH-1:0] sample_t;
    typedef logic signed [ACC_WIDTH-1:0]  acc_t;

    sample_t         x [NUM_TAPS];
    logic [PW-1:0]   phase;
    logic            cmp_pend;
    logic            acc_vld;
    acc_t            acc;
    acc_t            sum;
    sample_t         y;

    always_comb begin
        sum = '0;
        for (int k = 0; k < NUM_TAPS; k++)
            sum = sum + acc_t'(x[k]) * acc_t'(tap_coeffs[k]);
    end

    fir_sat_narrow #(
        .ACC_WIDTH (ACC_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .SHIFT     (TAP_COEFF_WIDTH - 1)
    ) u_narrow (
        .acc(acc),
        .y  (y)
    );

    // cmp_pend marks that the delay line now holds a decimating sample; the sum is taken one edge later
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_TAPS; k++) x[k] <= '0;
            phase     <= '0;
            cmp_pend  <= 1'b0;
            acc_vld   <= 1'b0;
            acc       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (in_valid) begin
                x[0] <= in;
                for (int k = 1; k < NUM_TAPS; k++) x[k] <= x[k-1];
                phase <= (phase == LAST_PH) ? '0 : phase + 1'b1;
            end
            cmp_pend  <= in_valid && (phase == LAST_PH);
            acc_vld   <= cmp_pend;
            if (cmp_pend) acc <= sum;
            out_valid <= acc_vld;
            if (acc_vld) out <= y;
        end
    end
endmodule
